// File: rtl/ext_obi_mem_responder.sv
// ext_obi_mem_responder
//
// OBI responder terminating one external-crossbar slave port in front of a
// fixed-latency SRAM macro. Requests are granted while an outstanding slot is
// free (or a response is leaving this cycle), range/alignment checked, and the
// valid ones are forwarded to memory in the grant cycle. Every grant, valid or
// not, produces exactly one response MEM_LATENCY cycles later, strictly in
// grant order. Invalid accesses never touch memory and answer err=1, rdata=0.
//
// Parameters
//   BASE_ADDR        byte base address of the memory window
//   NUM_WORDS        32-bit words in the window (power of 2, >= 2)
//   MEM_LATENCY      cycles from mem_req_o to valid mem_rdata_i (1..4)
//   MAX_OUTSTANDING  max granted-but-unanswered transactions (>= 1)
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   obi_req_i        request from the master
//   obi_we_i         1 = write
//   obi_be_i         byte enables
//   obi_addr_i       byte address
//   obi_wdata_i      write data
//   obi_gnt_o        grant, combinational from obi_req_i and internal state
//   obi_rvalid_o     one-cycle response strobe
//   obi_rdata_o      read data (0 for writes and errors)
//   obi_err_o        error response
//   mem_req_o        memory access strobe (grant cycle of a valid access)
//   mem_we_o         memory write enable
//   mem_be_o         memory byte enables
//   mem_addr_o       memory word address
//   mem_wdata_o      memory write data
//   mem_rdata_i      memory read data, valid MEM_LATENCY cycles after mem_req_o

module ext_obi_mem_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
    parameter int unsigned NUM_WORDS       = 1024,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         obi_req_i,
    input  logic                         obi_we_i,
    input  logic [3:0]                   obi_be_i,
    input  logic [31:0]                  obi_addr_i,
    input  logic [31:0]                  obi_wdata_i,
    output logic                         obi_gnt_o,
    output logic                         obi_rvalid_o,
    output logic [31:0]                  obi_rdata_o,
    output logic                         obi_err_o,

    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [3:0]                   mem_be_o,
    output logic [$clog2(NUM_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int unsigned ADDR_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [32:0]      WIN_BYTES = 33'(NUM_WORDS) << 2;
    localparam logic [32:0]      BASE_EXT  = {1'b0, BASE_ADDR};

    // Response tag carried down the latency pipeline, one per cycle.
    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } tag_t;

    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_next;
    logic [32:0]                 offset;
    logic                        addr_ok;
    tag_t                        new_tag;
    tag_t                        out_tag;
    tag_t [MEM_LATENCY-1:0]      pipe;
    tag_t [MEM_LATENCY-1:0]      pipe_next;

    // ------------------------------------------------------------------
    // Address decode. The offset is formed in 33 bits so an address below
    // the base produces a huge positive offset (bit 32 set) instead of
    // wrapping into the window; likewise addresses near 32'hFFFF_FFFC
    // cannot alias back into range.
    // ------------------------------------------------------------------
    always_comb begin
        offset  = {1'b0, obi_addr_i} - BASE_EXT;
        addr_ok = !offset[32] && (offset < WIN_BYTES) && (offset[1:0] == 2'b00);
    end

    // ------------------------------------------------------------------
    // Grant: a slot is available if fewer than MAX_OUTSTANDING are in
    // flight, or if the oldest one is leaving right now.
    // ------------------------------------------------------------------
    always_comb begin
        obi_gnt_o = obi_req_i && ((cnt < MAX_CNT) || obi_rvalid_o);
    end

    // ------------------------------------------------------------------
    // Memory side: the access is forwarded combinationally in the grant
    // cycle. Only mem_req_o is qualified; the remaining fields are simply
    // the request fields and are don't-care when mem_req_o is low.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o   = obi_gnt_o && addr_ok;
        mem_we_o    = obi_we_i;
        mem_be_o    = obi_be_i;
        mem_wdata_o = obi_wdata_i;
        mem_addr_o  = offset[ADDR_W+1:2];
    end

    // ------------------------------------------------------------------
    // Outstanding counter next-state. Grant and response in the same
    // cycle cancel out; by construction of the grant term the counter
    // can neither exceed MAX_OUTSTANDING nor underflow.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt;
        case ({obi_gnt_o, obi_rvalid_o})
            2'b10:   cnt_next = cnt + CNT_ONE;
            2'b01:   cnt_next = cnt - CNT_ONE;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline. Every cycle pushes a tag; idle cycles push an
    // invalid tag so that latency is fixed regardless of traffic. Stage 0
    // receives the new tag, stage MEM_LATENCY-1 drives the OBI response.
    // ------------------------------------------------------------------
    always_comb begin
        new_tag.valid = obi_gnt_o;
        new_tag.err   = obi_gnt_o && !addr_ok;
        new_tag.we    = obi_gnt_o && obi_we_i;
    end

    if (MEM_LATENCY == 1) begin : g_pipe_single
        assign pipe_next = new_tag;
    end else begin : g_pipe_multi
        assign pipe_next = {pipe[MEM_LATENCY-2:0], new_tag};
    end

    // Reset clears every stage, so responses in flight are dropped and
    // rvalid falls immediately because it is taken straight from the
    // last stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe <= '0;
        end else begin
            pipe <= pipe_next;
        end
    end

    // ------------------------------------------------------------------
    // Output stage. Read data is passed through from the memory only for
    // successful reads; writes and errors return zero.
    // ------------------------------------------------------------------
    always_comb begin
        out_tag      = pipe[MEM_LATENCY-1];
        obi_rvalid_o = out_tag.valid;
        obi_err_o    = out_tag.valid && out_tag.err;
        obi_rdata_o  = '0;
        if (out_tag.valid && !out_tag.err && !out_tag.we) begin
            obi_rdata_o = mem_rdata_i;
        end
    end

endmodule
